// File: rtl/me_search_ctrl_pkg.sv
// Shared constants, FSM state type and signed MV type for the integer-pel ME search controller.
package me_pkg;
  localparam int SR         = 4;
  localparam int ME_BLK     = 16;
  localparam int ME_BLK_PIX = 256;
  localparam int SAD_W      = 17;
  localparam int WIN        = ME_BLK + 2 * SR;
  localparam int REF_AW     = 10;
  localparam int MV_W       = 4;
  localparam int COST_W     = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_DRAIN,
    ST_CMP,
    ST_RESULT
  } me_state_e;

  typedef logic signed [MV_W-1:0] mv_t;

  // Magnitude of a MV component; -SR still fits because the result is unsigned.
  function automatic logic [MV_W-1:0] mv_mag(input mv_t m);
    return m[MV_W-1] ? MV_W'(-m) : MV_W'(m);
  endfunction
endpackage

// File: rtl/me_search_ctrl_if.sv
// Command, SRAM read, SAD engine and result signals of the ME search controller.
interface me_search_ctrl_if;
  import me_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            lambda;
  logic [7:0]            cur_rd_addr;
  logic [7:0]            cur_rd_data;
  logic [REF_AW-1:0]     ref_rd_addr;
  logic [7:0]            ref_rd_data;
  logic                  sad_start;
  logic [7:0]            sad_cur_pixel;
  logic [7:0]            sad_ref_pixel;
  logic                  sad_in_valid;
  logic                  sad_done;
  logic [SAD_W-1:0]      sad_value;
  logic                  result_valid;
  logic                  result_ready;
  mv_t                   best_mv_x;
  mv_t                   best_mv_y;
  logic [COST_W-1:0]     best_cost;

  modport master (
    input  cmd_valid, lambda, cur_rd_data, ref_rd_data, sad_done, sad_value, result_ready,
    output cmd_ready, cur_rd_addr, ref_rd_addr, sad_start, sad_cur_pixel, sad_ref_pixel,
           sad_in_valid, result_valid, best_mv_x, best_mv_y, best_cost
  );

  modport slave (
    output cmd_valid, lambda, cur_rd_data, ref_rd_data, sad_done, sad_value, result_ready,
    input  cmd_ready, cur_rd_addr, ref_rd_addr, sad_start, sad_cur_pixel, sad_ref_pixel,
           sad_in_valid, result_valid, best_mv_x, best_mv_y, best_cost
  );
endinterface

// File: rtl/me_search_ctrl_ref_addr_gen.sv
// Pixel counter plus current-block / reference-window address generation for one candidate.
// Addresses and the last flag are forced to zero whenever streaming is not enabled.
module me_ref_addr_gen
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  mv_t               u_i,
  input  mv_t               v_i,
  output logic [7:0]        cur_addr_o,
  output logic [REF_AW-1:0] ref_addr_o,
  output logic              last_o
);
  logic [7:0]        p_q, p_d;
  logic [3:0]        row, col;
  logic [REF_AW-1:0] ref_y, ref_x, ref_lin;

  always_comb begin
    p_d = p_q;
    if (clr_i) begin
      p_d = '0;
    end else if (en_i) begin
      p_d = p_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign row = p_q[7:4];
  assign col = p_q[3:0];

  // u+SR and v+SR are always in [0, 2*SR], so the window coordinates are non-negative.
  assign ref_y   = REF_AW'(int'(v_i) + SR) + REF_AW'(row);
  assign ref_x   = REF_AW'(int'(u_i) + SR) + REF_AW'(col);
  assign ref_lin = ref_y * REF_AW'(WIN) + ref_x;

  assign cur_addr_o = en_i ? p_q : '0;
  assign ref_addr_o = en_i ? ref_lin : '0;
  assign last_o     = en_i && (p_q == 8'hFF);
endmodule

// File: rtl/me_search_ctrl.sv
// Integer-pel full-search ME initiator: streams every candidate to the SAD engine, keeps the cheapest MV.
// Optional macro ME_RDO_COST_EN adds lambda*(|u|+|v|) to each candidate cost.
module me_search_ctrl
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  me_search_ctrl_if.master me_if
);
  me_state_e          state_q, state_d;
  mv_t                u_q, u_d, v_q, v_d;
  mv_t                best_x_q, best_x_d, best_y_q, best_y_d;
  logic [COST_W-1:0]  best_cost_q, best_cost_d, cost;
  logic [SAD_W-1:0]   sad_q, sad_d;
  logic               vld_q, vld_d;
  logic               cmd_ready, sad_start, result_valid;
  logic               addr_clr, stream_en, stream_last;
  logic [7:0]         cur_addr;
  logic [REF_AW-1:0]  ref_addr;

  me_ref_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (addr_clr),
    .en_i       (stream_en),
    .u_i        (u_q),
    .v_i        (v_q),
    .cur_addr_o (cur_addr),
    .ref_addr_o (ref_addr),
    .last_o     (stream_last)
  );

`ifdef ME_RDO_COST_EN
  localparam int MAG_W = $clog2(2 * SR) + 1;
  logic [7:0]         lambda_q, lambda_d;
  logic [MAG_W-1:0]   mag;
  logic [8+MAG_W-1:0] rdo;

  assign lambda_d = (state_q == ST_IDLE && me_if.cmd_valid) ? me_if.lambda : lambda_q;
  assign mag      = MAG_W'(mv_mag(u_q)) + MAG_W'(mv_mag(v_q));
  assign rdo      = (8 + MAG_W)'(lambda_q) * (8 + MAG_W)'(mag);
  assign cost     = COST_W'(sad_q) + COST_W'(rdo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lambda_q <= '0;
    end else begin
      lambda_q <= lambda_d;
    end
  end
`else
  logic unused_lambda;
  assign unused_lambda = ^me_if.lambda;
  assign cost          = COST_W'(sad_q);
`endif

  always_comb begin
    state_d      = state_q;
    u_d          = u_q;
    v_d          = v_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_cost_d  = best_cost_q;
    sad_d        = sad_q;
    cmd_ready    = 1'b0;
    sad_start    = 1'b0;
    result_valid = 1'b0;
    addr_clr     = 1'b0;
    stream_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (me_if.cmd_valid) begin
          u_d         = mv_t'(-SR);
          v_d         = mv_t'(-SR);
          best_cost_d = '1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        sad_start = 1'b1;
        addr_clr  = 1'b1;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        stream_en = 1'b1;
        if (stream_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (me_if.sad_done) begin
          sad_d   = me_if.sad_value;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        // Strict compare: on a tie the earlier candidate in raster order wins.
        if (cost < best_cost_q) begin
          best_cost_d = cost;
          best_x_d    = u_q;
          best_y_d    = v_q;
        end
        if (u_q == mv_t'(SR) && v_q == mv_t'(SR)) begin
          state_d = ST_RESULT;
        end else begin
          if (u_q == mv_t'(SR)) begin
            u_d = mv_t'(-SR);
            v_d = v_q + mv_t'(1);
          end else begin
            u_d = u_q + mv_t'(1);
          end
          state_d = ST_START;
        end
      end
      ST_RESULT: begin
        result_valid = 1'b1;
        if (me_if.result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign vld_d = stream_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      u_q         <= '0;
      v_q         <= '0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      best_cost_q <= '0;
      sad_q       <= '0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      v_q         <= v_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      best_cost_q <= best_cost_d;
      sad_q       <= sad_d;
      vld_q       <= vld_d;
    end
  end

  // SRAM data lands one cycle after its address, so vld_q lines up with the read data.
  assign me_if.cmd_ready     = cmd_ready;
  assign me_if.sad_start     = sad_start;
  assign me_if.cur_rd_addr   = cur_addr;
  assign me_if.ref_rd_addr   = ref_addr;
  assign me_if.sad_in_valid  = vld_q;
  assign me_if.sad_cur_pixel = vld_q ? me_if.cur_rd_data : '0;
  assign me_if.sad_ref_pixel = vld_q ? me_if.ref_rd_data : '0;
  assign me_if.result_valid  = result_valid;
  assign me_if.best_mv_x     = best_x_q;
  assign me_if.best_mv_y     = best_y_q;
  assign me_if.best_cost     = best_cost_q;
endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: SRAM and SAD-engine models plus a full-search reference model.
module tb_me_search_ctrl;
  import me_pkg::*;

  localparam int NCAND = (2 * SR + 1) * (2 * SR + 1);
  localparam int LAT   = NCAND * 260;

  typedef struct {
    int cand;
    int p;
    int exp_cur;
    int exp_ref;
  } addr_vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  me_search_ctrl_if bus ();

  me_search_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .me_if (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] cur_mem [256];
  logic [7:0] win_mem [1024];
  int  ovr_sad [NCAND];
  bit  ovr_en   = 1'b0;
  int  ovr_base = 0;
  int  sbase    = 0;
  int  vbase    = 0;
  int  start_cnt = 0;
  int  vld_total = 0;
  int  acc = 0;
  int  pix_cnt = 0;
  int  prev_addr = 0;
  int  addr_log [NCAND*256];
  int  cand_vld [NCAND];

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int ovr_pick(input int c);
    return (c >= 0 && c < NCAND) ? ovr_sad[c] : 32'h1FFFF;
  endfunction

  // Read-latency-1 SRAMs.
  always @(posedge clk) begin
    bus.cur_rd_data <= cur_mem[bus.cur_rd_addr];
    bus.ref_rd_data <= win_mem[bus.ref_rd_addr];
  end

  // SAD engine: accumulate 256 |cur-ref| terms after start, pulse done the following cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= 0;
      pix_cnt       <= 0;
      bus.sad_done  <= 1'b0;
      bus.sad_value <= '0;
    end else begin
      bus.sad_done <= 1'b0;
      if (bus.sad_start === 1'b1) begin
        acc       <= 0;
        pix_cnt   <= 0;
        start_cnt <= start_cnt + 1;
      end else if (bus.sad_in_valid === 1'b1) begin
        acc     <= acc + absd(int'(bus.sad_cur_pixel), int'(bus.sad_ref_pixel));
        pix_cnt <= pix_cnt + 1;
        if (pix_cnt == 255) begin
          bus.sad_done  <= 1'b1;
          bus.sad_value <= ovr_en ? 17'(ovr_pick(start_cnt - 1 - ovr_base))
                                  : 17'(acc + absd(int'(bus.sad_cur_pixel), int'(bus.sad_ref_pixel)));
        end
      end
    end
  end

  // Log each streamed pixel's {cur,ref} address (issued the cycle before its in_valid).
  always @(negedge clk) begin
    prev_addr <= int'(bus.cur_rd_addr) * 1024 + int'(bus.ref_rd_addr);
    if (bus.sad_in_valid === 1'b1) begin
      if (vld_total - vbase >= 0 && vld_total - vbase < NCAND * 256)
        addr_log[vld_total - vbase] <= prev_addr;
      if (start_cnt - sbase >= 1 && start_cnt - sbase <= NCAND)
        cand_vld[start_cnt - sbase - 1] <= cand_vld[start_cnt - sbase - 1] + 1;
      vld_total <= vld_total + 1;
    end
  end

  // Reference: exhaustive search in raster order, strict less-than keeps the first minimum.
  function automatic void ref_best(input int lam, input bit use_ovr,
                                   output int bx, output int by, output int bc);
    int sad, cost, rdo_w;
    rdo_w = 0;
`ifdef ME_RDO_COST_EN
    rdo_w = lam;
`endif
    bc = (1 << COST_W) - 1;
    bx = 0;
    by = 0;
    for (int v = -SR; v <= SR; v++) begin
      for (int u = -SR; u <= SR; u++) begin
        if (use_ovr) begin
          sad = ovr_sad[(v + SR) * (2 * SR + 1) + (u + SR)];
        end else begin
          sad = 0;
          for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
              sad += absd(int'(cur_mem[i*16+j]), int'(win_mem[(v+SR+i)*WIN + (u+SR+j)]));
        end
        cost = sad + rdo_w * (((u < 0) ? -u : u) + ((v < 0) ? -v : v));
        if (cost < bc) begin
          bc = cost;
          bx = u;
          by = v;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " cmd_ready"},     32'(bus.cmd_ready), 1);
    check({tag, " sad_start"},     32'(bus.sad_start), 0);
    check({tag, " sad_in_valid"},  32'(bus.sad_in_valid), 0);
    check({tag, " result_valid"},  32'(bus.result_valid), 0);
    check({tag, " cur_rd_addr"},   32'(bus.cur_rd_addr), 0);
    check({tag, " ref_rd_addr"},   32'(bus.ref_rd_addr), 0);
    check({tag, " sad_cur_pixel"}, 32'(bus.sad_cur_pixel), 0);
    check({tag, " sad_ref_pixel"}, 32'(bus.sad_ref_pixel), 0);
    check({tag, " best_mv_x"},     32'(bus.best_mv_x), 0);
    check({tag, " best_mv_y"},     32'(bus.best_mv_y), 0);
    check({tag, " best_cost"},     32'(bus.best_cost), 0);
  endtask

  task automatic do_accept(input string tag, input int lam);
    @(negedge clk);
    check({tag, " cmd_ready before accept"}, 32'(bus.cmd_ready), 1);
    bus.lambda    = 8'(lam);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input bit poke);
    int n;
    n = 0;
    while (bus.result_valid !== 1'b1 && n < LAT + 100) begin
      @(posedge clk);
      #1;
      n++;
      if (poke) bus.cmd_valid = (n >= 5000 && n < 5004);
    end
    bus.cmd_valid = 1'b0;
    check({tag, " accept-to-result cycles"}, n, LAT);
  endtask

  task automatic check_result(input string tag, input int ex, input int ey, input int ec);
    check({tag, " result_valid"}, 32'(bus.result_valid), 1);
    check({tag, " best_mv_x"},    32'(bus.best_mv_x), ex);
    check({tag, " best_mv_y"},    32'(bus.best_mv_y), ey);
    check({tag, " best_cost"},    32'(bus.best_cost), ec);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    check({tag, " result_valid after accept"}, 32'(bus.result_valid), 0);
    check({tag, " cmd_ready after accept"},    32'(bus.cmd_ready), 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_vec_t avec [7];
    int bx, by, bc, bad, k, hx, hy, hc, s0, c, v, u;

    avec[0] = '{0,  0,   0,   0};
    avec[1] = '{80, 255, 255, 575};
    avec[2] = '{40, 0,   0,   100};
    avec[3] = '{40, 17,  17,  125};
    avec[4] = '{8,  15,  15,  23};
    avec[5] = '{72, 240, 240, 552};
    avec[6] = '{41, 0,   0,   101};

    bus.cmd_valid    = 1'b0;
    bus.result_ready = 1'b0;
    bus.lambda       = 8'd0;

    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // A: random window, exact copy of the block planted at (+2,-1).
    for (int i = 0; i < 256; i++)  cur_mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) win_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        win_mem[(-1 + SR + i) * WIN + (2 + SR + j)] = cur_mem[i*16+j];
    sbase = start_cnt;
    vbase = vld_total;
    do_accept("A", 0);
    wait_result("A", 1'b1);
    check_result("A", 2, -1, 0);
    ref_best(0, 1'b0, bx, by, bc);
    check_result("A model", bx, by, bc);
    check("A sad_start count", start_cnt - sbase, NCAND);
    bad = 0;
    for (int i = 0; i < NCAND; i++) if (cand_vld[i] != 256) bad++;
    check("A candidates without 256 in_valid", bad, 0);
    for (int t = 0; t < 7; t++) begin
      k = addr_log[avec[t].cand * 256 + avec[t].p];
      check($sformatf("A cur_rd_addr vec%0d", t), k / 1024, avec[t].exp_cur);
      check($sformatf("A ref_rd_addr vec%0d", t), k % 1024, avec[t].exp_ref);
    end
    bad = 0;
    for (int cc = 0; cc < NCAND; cc++) begin
      v = cc / (2 * SR + 1) - SR;
      u = cc % (2 * SR + 1) - SR;
      for (int p = 0; p < 256; p++)
        if (addr_log[cc*256+p] != p * 1024 + (v + SR + p / 16) * WIN + (u + SR + p % 16)) bad++;
    end
    check("A address sweep errors", bad, 0);

    // Result held 10 cycles while a second command waits.
    hx = int'(bus.best_mv_x);
    hy = int'(bus.best_mv_y);
    hc = int'(bus.best_cost);
    s0 = start_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d result_valid", i), 32'(bus.result_valid), 1);
      check($sformatf("hold%0d cmd_ready", i),    32'(bus.cmd_ready), 0);
      check($sformatf("hold%0d mv_x", i),         32'(bus.best_mv_x), hx);
      check($sformatf("hold%0d mv_y", i),         32'(bus.best_mv_y), hy);
      check($sformatf("hold%0d cost", i),         32'(bus.best_cost), hc);
    end
    bus.cmd_valid = 1'b0;
    check("hold no new search", start_cnt - s0, 0);
    handshake("A");

    // B: reset pulsed in the middle of candidate 30's stream.
    for (int i = 0; i < 256; i++)  cur_mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) win_mem[i] = 8'($urandom);
    sbase = start_cnt;
    do_accept("B", 0);
    c = 0;
    while (start_cnt - sbase < 31 && c < 20000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("B reached candidate 30", start_cnt - sbase, 31);
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s0  = start_cnt;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.result_valid !== 1'b0 || bus.sad_start !== 1'b0) bad++;
    end
    check("B activity after abort", bad, 0);
    check("B starts after abort", start_cnt - s0, 0);

    // C: flat 128 everywhere, every SAD zero, tie rule keeps (-4,-4).
    for (int i = 0; i < 256; i++)  cur_mem[i] = 8'd128;
    for (int i = 0; i < 1024; i++) win_mem[i] = 8'd128;
    do_accept("C", 0);
    wait_result("C", 1'b0);
    check_result("C", -SR, -SR, 0);
    ref_best(0, 1'b0, bx, by, bc);
    check_result("C model", bx, by, bc);
    handshake("C");

    // D: injected SADs: 0 at (4,4), 100 at (0,0), random >= 5000 elsewhere, lambda 20.
    for (int i = 0; i < NCAND; i++) ovr_sad[i] = 5000 + $urandom_range(60000, 0);
    ovr_sad[80] = 0;
    ovr_sad[40] = 100;
    ovr_base = start_cnt;
    ovr_en   = 1'b1;
    do_accept("D", 20);
    wait_result("D", 1'b0);
`ifdef ME_RDO_COST_EN
    check_result("D", 0, 0, 100);
`else
    check_result("D", 4, 4, 0);
`endif
    ref_best(20, 1'b1, bx, by, bc);
    check_result("D model", bx, by, bc);
    handshake("D");
    ovr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Initiator side of the streaming 16x16 SAD engine (sad16x16).
- Runs an integer-pel full search over a (2*SR+1)^2 window. For each candidate (u,v) it pulses start, streams 256 cur/ref pixel pairs from local block and window SRAMs, collects done/sad_out and keeps the minimum-cost vector.
- Sits in the video encode ME unit, between the reference-window loader and the sub-pel refinement stage.

Parameters:
- SR, 4, search radius; candidates u,v in [-SR,+SR].
- WIN, 16+2*SR (24), reference window width and height in pixels.
- REF_AW, 10, reference window address width; must satisfy 2^REF_AW >= WIN*WIN.
- MV_W, 4, signed MV component width; must hold ±SR.
- COST_W, 20, cost width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  search request
- cmd_ready  out  1  high only in IDLE
- lambda  in  8  RDO weight, sampled on cmd accept (ignored unless ME_RDO_COST_EN)
- cur_rd_addr  out  8  current-block SRAM address, row-major i*16+j
- cur_rd_data  in  8  data for the address issued one cycle earlier
- ref_rd_addr  out  REF_AW  window SRAM address
- ref_rd_data  in  8  data for the address issued one cycle earlier
- sad_start  out  1  one-cycle start pulse to the SAD engine
- sad_cur_pixel  out  8  to SAD engine cur_pixel
- sad_ref_pixel  out  8  to SAD engine ref_pixel
- sad_in_valid  out  1  to SAD engine in_valid
- sad_done  in  1  from SAD engine
- sad_value  in  17  from SAD engine sad_out
- result_valid  out  1  best vector available
- result_ready  in  1  consumer accept
- best_mv_x  out  MV_W  signed best u
- best_mv_y  out  MV_W  signed best v
- best_cost  out  COST_W  best cost

Behaviour:
- Reset: asynchronous, active-low; all state cleared. State=IDLE, cmd_ready=1, sad_start=0, sad_in_valid=0, result_valid=0, all address/data/MV/cost outputs 0.
- Reset mid-search: immediate abort to IDLE. No partial result is produced.
- FSM states: IDLE, START, STREAM, DRAIN, CMP, RESULT.
- IDLE: on cmd_valid&&cmd_ready, latch lambda, set (u,v)=(-SR,-SR), best_cost=all-ones → START.
- START: sad_start=1 for exactly one cycle; pixel counter p=0 → STREAM.
- STREAM: 256 cycles, p=0..255. Address generation for pixel p (i=p>>4, j=p&15):
  - cur_rd_addr=p
  - ref_rd_addr=(v+SR+i)*WIN+(u+SR+j)
- Data pipeline: sad_in_valid is the address-valid delayed one cycle, aligned with the SRAM data. sad_cur_pixel/sad_ref_pixel are the SRAM read data passed straight through. After p=255 → DRAIN.
- DRAIN: the last sad_in_valid occurs here. Wait for sad_done, then latch sad_value → CMP. No timeout.
- CMP (1 cycle):
  - cost = zero-extended sad_value (RDO term added per Optional Feature).
  - If cost < best_cost (strict), update best_cost and best MV, so ties keep the earlier candidate.
  - Scan order: v outer, u inner, both ascending.
  - If (u,v)=(SR,SR) → RESULT; else advance and → START.
- Per-candidate latency: 260 cycles (START 1, STREAM 256, DRAIN 2, CMP 1). Default total: 81*260 = 21060 cycles from accept to result_valid.
- RESULT: result_valid=1; outputs held stable until result_ready. On accept: result_valid=0 → IDLE, cmd_ready=1 next cycle.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- sad_done outside DRAIN is ignored.
- MV components are two's complement, sign-extended to MV_W.

Optional Feature:
- Macro: ME_RDO_COST_EN.
- Defined: cost = sad_value + lambda*(|u|+|v|). Product is 8x(clog2(2*SR)+1) bits; sum is COST_W bits with no overflow (max 65280+2040).
- Undefined: cost = sad_value. The lambda input is unused and no lambda register is synthesized.

Decomposition:
- Shared package me_pkg:
  - constants ME_BLK=16, ME_BLK_PIX=256, SAD_W=17
  - state enum type
  - mv_t signed typedef
- Sub-module me_ref_addr_gen (combinational plus counter): from p, u, v produces cur_rd_addr, ref_rd_addr and the stream-last flag.

Test Plan:
- Window random; ref block at offset (+2,-1) equals the current block → best_mv=(2,-1), best_cost=0, result_valid 21060 cycles after accept.
- All pixels constant 128 → every SAD 0; tie rule gives best_mv=(-4,-4), best_cost=0.
- Address check: candidate (-4,-4), p=0 → ref_rd_addr=0; candidate (4,4), p=255 → ref_rd_addr=575. sad_in_valid is high exactly 256 cycles per candidate.
- result_ready held low 10 cycles → result outputs stable, cmd_ready=0, a second cmd_valid is not accepted until after the result handshake.
- rst_n pulsed low mid-STREAM of candidate 30 → all outputs take reset values asynchronously; a fresh search then returns the correct result.
- ME_RDO_COST_EN defined, lambda=20; SAD 0 at (4,4) and 100 at (0,0), all other candidates ≥5000 → best_mv=(0,0), cost=100. With the macro undefined → best_mv=(4,4), cost=0.
